// File: rtl/correlation_readout_scheduler.sv
// Correlation readout scheduler: generates sample and integration strobes and,
// on each integration boundary, snapshots all correlator counts and streams them
// as a framed byte sequence (header, sequence, data, XOR checksum) to a UART.
// Ports:
//   clk, reset             - single clock, synchronous active-high reset
//   enable                 - run/stop for the sample and integration timers
//   count_in               - live counts, correlator k at [k*RESOLUTION +: RESOLUTION]
//   sample_clk_pulse       - one-cycle sample strobe
//   integration_clk_pulse  - one-cycle end-of-integration strobe
//   clear_counts           - accumulator clear, same timing as integration_clk_pulse
//   tx_data/tx_valid/tx_ready - byte stream to the transmitter (valid/ready handshake)
//   overrun                - sticky: an integration period was dropped
module correlation_readout_scheduler #(
  parameter int unsigned NUM_CORRELATORS    = 45,
  parameter int unsigned RESOLUTION         = 20,
  parameter int unsigned INTEGRATION_CYCLES = 50000000,
  parameter int unsigned SAMPLE_CYCLES      = 50
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [NUM_CORRELATORS*RESOLUTION-1:0] count_in,
  output logic                                  sample_clk_pulse,
  output logic                                  integration_clk_pulse,
  output logic                                  clear_counts,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic                                  overrun
);

  localparam int unsigned BYTES    = (RESOLUTION + 7) / 8;
  localparam int unsigned PAD_W    = BYTES * 8;
  localparam int unsigned SAMPLE_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned INT_W    = (INTEGRATION_CYCLES > 1) ? $clog2(INTEGRATION_CYCLES) : 1;
  localparam int unsigned CORR_W   = (NUM_CORRELATORS > 1) ? $clog2(NUM_CORRELATORS) : 1;
  localparam int unsigned BYTE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0]  HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, HEADER, SEQ, DATA, CHECKSUM} state_t;

  state_t                                state, state_next;
  logic [SAMPLE_W-1:0]                   sample_timer;
  logic [INT_W-1:0]                      int_timer;
  logic [7:0]                            seq_count, seq_frame, checksum;
  logic [NUM_CORRELATORS*RESOLUTION-1:0] snapshot;
  logic [CORR_W-1:0]                     corr_idx;
  logic [BYTE_W-1:0]                     byte_idx;
  logic                                  overrun_flag;

  logic                  sample_term, int_term, boundary, transfer, capture, last_data;
  logic [RESOLUTION-1:0] word;
  logic [PAD_W-1:0]      padded;
  logic [7:0]            data_byte, frame_byte;

  assign sample_term = (sample_timer == SAMPLE_W'(SAMPLE_CYCLES - 1));
  assign int_term    = (int_timer == INT_W'(INTEGRATION_CYCLES - 1));
  assign boundary    = enable && int_term;
  assign transfer    = (state != IDLE) && tx_ready;
  // A boundary landing on the final checksum transfer is treated as idle.
  assign capture     = boundary && ((state == IDLE) || ((state == CHECKSUM) && transfer));
  assign last_data   = (corr_idx == CORR_W'(NUM_CORRELATORS - 1)) &&
                       (byte_idx == BYTE_W'(BYTES - 1));

  // Select current correlator word, then its byte, most-significant first.
  always_comb begin
    word      = '0;
    data_byte = '0;
    for (int unsigned k = 0; k < NUM_CORRELATORS; k++) begin
      if (corr_idx == CORR_W'(k)) word = snapshot[k*RESOLUTION +: RESOLUTION];
    end
    padded = PAD_W'(word);
    for (int unsigned j = 0; j < BYTES; j++) begin
      if (byte_idx == BYTE_W'(j)) data_byte = padded[(BYTES-1-j)*8 +: 8];
    end
  end

  // Frame byte mux and next-state logic.
  always_comb begin
    state_next = state;
    frame_byte = 8'h00;
    case (state)
      IDLE: begin
        if (capture) state_next = HEADER;
      end
      HEADER: begin
        frame_byte = HEADER_BYTE;
        if (transfer) state_next = SEQ;
      end
      SEQ: begin
        frame_byte = seq_frame;
        if (transfer) state_next = DATA;
      end
      DATA: begin
        frame_byte = data_byte;
        if (transfer && last_data) state_next = CHECKSUM;
      end
      CHECKSUM: begin
        frame_byte = checksum;
        if (transfer) state_next = capture ? HEADER : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Timers, sequence, snapshot, checksum and byte position.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_timer <= '0;
      int_timer    <= '0;
      seq_count    <= '0;
      seq_frame    <= '0;
      snapshot     <= '0;
      checksum     <= '0;
      corr_idx     <= '0;
      byte_idx     <= '0;
      overrun_flag <= 1'b0;
    end else begin
      if (enable) begin
        sample_timer <= sample_term ? '0 : sample_timer + SAMPLE_W'(1);
        int_timer    <= int_term ? '0 : int_timer + INT_W'(1);
      end else begin
        sample_timer <= '0;
        int_timer    <= '0;
      end
      if (boundary) seq_count <= seq_count + 8'd1;
      if (boundary && !capture) overrun_flag <= 1'b1;
      if (capture) begin
        snapshot  <= count_in;
        seq_frame <= seq_count;
        checksum  <= '0;
      end else if (transfer) begin
        checksum <= checksum ^ frame_byte;
      end
      if (capture) begin
        corr_idx <= '0;
        byte_idx <= '0;
      end else if ((state == DATA) && transfer) begin
        if (byte_idx == BYTE_W'(BYTES - 1)) begin
          byte_idx <= '0;
          corr_idx <= (corr_idx == CORR_W'(NUM_CORRELATORS - 1)) ? '0 : corr_idx + CORR_W'(1);
        end else begin
          byte_idx <= byte_idx + BYTE_W'(1);
        end
      end
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign sample_clk_pulse      = !reset && enable && sample_term;
  assign integration_clk_pulse = !reset && boundary;
  assign clear_counts          = !reset && boundary;
  assign tx_valid              = !reset && (state != IDLE);
  assign tx_data               = reset ? 8'h00 : frame_byte;
  assign overrun               = !reset && overrun_flag;

endmodule

// File: tb/tb_correlation_readout_scheduler.sv
// Directed self-checking bench for correlation_readout_scheduler with a small
// configuration (2 correlators, 20-bit counts, 100-cycle integration, 10-cycle sample).
module tb_correlation_readout_scheduler;

  localparam int unsigned NUM = 2;
  localparam int unsigned RES = 20;

  logic           clk = 1'b0;
  logic           reset, enable, tx_ready;
  logic [NUM*RES-1:0] count_in;
  logic           sample_clk_pulse, integration_clk_pulse, clear_counts, tx_valid, overrun;
  logic [7:0]     tx_data;

  int n_vec = 0;
  int n_err = 0;

  logic       o_sp, o_ip, o_cc, o_v, o_ov;
  logic [7:0] o_d;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  correlation_readout_scheduler #(
    .NUM_CORRELATORS(NUM), .RESOLUTION(RES),
    .INTEGRATION_CYCLES(100), .SAMPLE_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .count_in(count_in),
    .sample_clk_pulse(sample_clk_pulse), .integration_clk_pulse(integration_clk_pulse),
    .clear_counts(clear_counts), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, record accepted bytes.
  task automatic cyc();
    @(negedge clk);
    o_sp = sample_clk_pulse; o_ip = integration_clk_pulse; o_cc = clear_counts;
    o_v  = tx_valid; o_ov = overrun; o_d = tx_data;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; enable = 1'b1; tx_ready = 1'b1;
    cyc();
    check({tag, "_rst_valid"}, 32'(o_v), 32'd0);
    check({tag, "_rst_data"},  32'(o_d), 32'd0);
    check({tag, "_rst_ovr"},   32'(o_ov), 32'd0);
    check({tag, "_rst_int"},   32'(o_ip), 32'd0);
    reset = 1'b0; enable = 1'b0;
    got_q.delete();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx_ready = 1'b1;
    count_in = {20'hABCDE, 20'h12345};

    // Basic frame and sample strobe cadence
    do_reset("t1");
    enable = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      cyc();
      check($sformatf("t1_sample_%0d", n), 32'(o_sp), 32'(n % 10 == 0));
      check($sformatf("t1_int_%0d", n),    32'(o_ip), 32'(n == 100));
      check($sformatf("t1_clr_%0d", n),    32'(o_cc), 32'(n == 100));
      check($sformatf("t1_valid_%0d", n),  32'(o_v),  32'(n >= 101 && n <= 109));
    end
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'hAA};
    compare_frame("t1_frame");
    check("t1_ovr", 32'(o_ov), 32'd0);

    // Backpressure during DATA holds the byte
    do_reset("t2");
    enable = 1'b1;
    for (int n = 1; n <= 115; n++) begin
      tx_ready = !(n >= 103 && n <= 107);
      cyc();
      if (n >= 103 && n <= 107) begin
        check($sformatf("t2_hold_valid_%0d", n), 32'(o_v), 32'd1);
        check($sformatf("t2_hold_data_%0d", n),  32'(o_d), 32'h01);
      end
    end
    compare_frame("t2_frame");

    // Boundary coincident with the checksum transfer
    do_reset("t3");
    enable = 1'b1;
    for (int n = 1; n <= 210; n++) begin
      tx_ready = (n >= 192);
      cyc();
      if (n == 200) begin
        check("t3_int_200", 32'(o_ip), 32'd1);
        check("t3_ck_200",  32'(o_d),  32'hAA);
      end
      if (n == 201) begin
        check("t3_valid_201", 32'(o_v), 32'd1);
        check("t3_hdr_201",   32'(o_d), 32'hA5);
      end
      if (n == 202) check("t3_seq_202", 32'(o_d), 32'h01);
    end
    check("t3_ovr", 32'(o_ov), 32'd0);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'hAA,
              8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'hAB};
    compare_frame("t3_frames");

    // Overrun: second boundary dropped, sequence still advances
    do_reset("t4");
    enable = 1'b1;
    for (int n = 1; n <= 304; n++) begin
      tx_ready = (n > 250);
      cyc();
      if (n == 199) check("t4_ovr_199", 32'(o_ov), 32'd0);
      if (n == 201) check("t4_ovr_201", 32'(o_ov), 32'd1);
      if (n == 300) check("t4_int_300", 32'(o_ip), 32'd1);
    end
    check("t4_ovr_end", 32'(o_ov), 32'd1);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'hAA,
              8'hA5, 8'h02, 8'h01, 8'h23};
    compare_frame("t4_frames");

    // Reset mid-frame (DUT is now in DATA of the SEQ=02 frame)
    reset = 1'b1; enable = 1'b1; tx_ready = 1'b1;
    cyc();
    check("t5_rst_valid", 32'(o_v),  32'd0);
    check("t5_rst_ovr",   32'(o_ov), 32'd0);
    check("t5_rst_data",  32'(o_d),  32'd0);
    reset = 1'b0; enable = 1'b0;
    cyc();
    check("t5_post_valid", 32'(o_v),  32'd0);
    check("t5_post_ovr",   32'(o_ov), 32'd0);
    got_q.delete();
    count_in = {20'h00FFF, 20'hFFFFF};
    enable = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      cyc();
      if (n == 100) check("t5_int_100", 32'(o_ip), 32'd1);
    end
    exp_q = '{8'hA5, 8'h00, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'hFF, 8'h5A};
    compare_frame("t5_frame");

    // Enable drop at timer value 60
    do_reset("t6");
    enable = 1'b1;
    for (int n = 1; n <= 60; n++) cyc();
    enable = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      check($sformatf("t6_off_int_%0d", n), 32'(o_ip), 32'd0);
      check($sformatf("t6_off_sp_%0d", n),  32'(o_sp), 32'd0);
    end
    enable = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      check($sformatf("t6_on_int_%0d", n), 32'(o_ip), 32'(n == 100));
      check($sformatf("t6_on_sp_%0d", n),  32'(o_sp), 32'(n % 10 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
